dff_piso_tx: RTL

Frame transmitter for the 10-lane DFF serial data interface. It accepts ten 12-bit words, then drives `load` and a generated `shift_clk`, sending all ten lanes in parallel with the LSB first. One frame is exactly 12 rising `shift_clk` edges, so the 12-bit counter at the receiving (capture) end stays aligned frame to frame. The block sits on the FPGA. It either writes DFF-chain patterns into the testchip or drives a loopback into the capture block for self-test.

---
 rtl/dff_io_pkg.sv | 20 ++
 rtl/shift_tick_gen.sv | 26 ++
 rtl/dff_piso_tx.sv | 110 +++++++++++
 3 files changed

// File: rtl/dff_io_pkg.sv
// Shared constants and types for the 10-lane DFF serial data interface.
// Lane k of a packed frame word sits at bits [lane_lsb(k) +: NBITS].
package dff_io_pkg;

  localparam int NLANES = 10;
  localparam int NBITS  = 12;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LOW,
    HIGH,
    DONE
  } piso_state_t;

  function automatic int lane_lsb(input int k);
    return k * NBITS;
  endfunction

endpackage

// File: rtl/shift_tick_gen.sv
// Divider for the shift clock: a one-cycle tick after DIV cycles in a phase.
// The counter stops at DIV-1 and is cleared whenever the phase ends or restarts.
module shift_tick_gen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  logic [7:0] cnt_q, cnt_d;

  assign tick = (cnt_q == 8'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (restart || tick) cnt_d = 8'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 8'd0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dff_piso_tx.sv
// Frame transmitter: latches ten 12-bit words and sends them LSB first on
// ten lanes with a generated shift_clk; exactly NBITS rising edges per frame.
module dff_piso_tx
  import dff_io_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [NLANES*NBITS-1:0] data_in,
  output logic                    shift_clk,
  output logic                    load,
  output logic [NLANES-1:0]       q,
  output logic                    busy,
  output logic                    done
);

  piso_state_t                        state_q, state_d;
  logic [3:0]                         idx_q, idx_d;
  logic [NLANES-1:0][NBITS-1:0]       shadow_q, shadow_d;
  logic [NLANES-1:0]                  q_q, q_d;
  logic                               sclk_q, sclk_d;
  logic                               load_q, load_d;
  logic                               busy_q, busy_d;
  logic                               done_q, done_d;
  logic                               tick;
  logic                               restart;

  // IDLE and DONE do not use the divider, so keep it parked at zero there.
  assign restart = (state_q == IDLE) || (state_q == DONE);

  shift_tick_gen #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .tick    (tick)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    q_d      = q_q;
    case (state_q)
      IDLE: if (start) begin
        for (int k = 0; k < NLANES; k++)
          shadow_d[k] = data_in[lane_lsb(k) +: NBITS];
        idx_d   = 4'd0;
        state_d = SETUP;
      end
      SETUP: if (tick) begin
        idx_d   = 4'd0;
        state_d = LOW;
      end
      LOW: if (tick) state_d = HIGH;
      HIGH: if (tick) begin
        if (idx_q == 4'(NBITS - 1)) begin
          idx_d   = 4'd0;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = LOW;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they register with it.
    sclk_d = (state_d == HIGH);
    load_d = !((state_d == LOW) || (state_d == HIGH));
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    if (state_d == LOW && state_q != LOW) begin
      for (int k = 0; k < NLANES; k++) q_d[k] = shadow_q[k][idx_d];
    end else if (state_d != HIGH && state_d != LOW) begin
      q_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= 4'd0;
      shadow_q <= '0;
      q_q      <= '0;
      sclk_q   <= 1'b0;
      load_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      q_q      <= q_d;
      sclk_q   <= sclk_d;
      load_q   <= load_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign shift_clk = sclk_q;
  assign load      = load_q;
  assign q         = q_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
